// File: rtl/vga_fb_scan.sv
// vga_fb_scan: programmable VGA timing generator with an indexed, scaled
// framebuffer and a colour palette. Three-stage scan pipeline (address,
// framebuffer read, palette lookup) with all video outputs registered.
module vga_fb_scan #(
  parameter int unsigned HD             = 1280,
  parameter int unsigned HF             = 48,
  parameter int unsigned HR             = 112,
  parameter int unsigned HB             = 248,
  parameter int unsigned VD             = 1024,
  parameter int unsigned VF             = 1,
  parameter int unsigned VR             = 3,
  parameter int unsigned VB             = 38,
  parameter bit          HS_POL         = 1'b1,
  parameter bit          VS_POL         = 1'b1,
  parameter int unsigned FB_W           = 320,
  parameter int unsigned FB_H           = 256,
  parameter int unsigned SCALE_LOG2     = 2,
  parameter int unsigned IDX_BITS       = 2,
  parameter int unsigned RGB_BITS       = 12,
  parameter int unsigned COORD_BITS     = 11,
  parameter bit          WR_VBLANK_ONLY = 1'b0
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [COORD_BITS-1:0] wr_x_i,
  input  logic [COORD_BITS-1:0] wr_y_i,
  input  logic [IDX_BITS-1:0]   wr_idx_i,
  output logic                  wr_drop_o,
  input  logic                  pal_we_i,
  input  logic [IDX_BITS-1:0]   pal_addr_i,
  input  logic [RGB_BITS-1:0]   pal_data_i,
  output logic                  hsync_o,
  output logic                  vsync_o,
  output logic                  de_o,
  output logic [RGB_BITS-1:0]   rgb_o,
  output logic                  frame_start_o
);

  localparam int unsigned HTOT  = HD + HF + HR + HB;
  localparam int unsigned VTOT  = VD + VF + VR + VB;
  localparam int unsigned HCW   = $clog2(HTOT);
  localparam int unsigned VCW   = $clog2(VTOT);
  localparam int unsigned FB_N  = FB_W * FB_H;
  localparam int unsigned FB_AW = $clog2(FB_N);
  localparam int unsigned PAL_N = 1 << IDX_BITS;
  localparam int unsigned H_DS  = HR + HB;
  localparam int unsigned H_DE  = HR + HB + HD;
  localparam int unsigned V_DS  = VR + VB;
  localparam int unsigned V_DE  = VR + VB + VD;

  logic [HCW-1:0]      hcnt;
  logic [VCW-1:0]      vcnt;

  logic [31:0]         h32, v32, sx, sy, fx, fy;
  logic                h_act, v_act, de_raw, hs_raw, vs_raw, fs_raw, in_fb_c;
  logic [FB_AW-1:0]    addr_c;

  logic [FB_AW-1:0]    s1_addr;
  logic                s1_infb, s1_de, s1_hs, s1_vs, s1_fs;
  logic                s2_infb, s2_de, s2_hs, s2_vs, s2_fs;

  logic [IDX_BITS-1:0] fb_mem [FB_N];
  logic [IDX_BITS-1:0] fb_rdata;
  logic [RGB_BITS-1:0] pal [PAL_N];
  logic [IDX_BITS-1:0] lkp_idx;

  logic                wr_in_range, wr_accept, fb_we;
  logic [FB_AW-1:0]    fb_waddr;

  // Horizontal/vertical scan counters; vcnt steps at the end of each line.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == HCW'(HTOT - 1)) begin
      hcnt <= '0;
      vcnt <= (vcnt == VCW'(VTOT - 1)) ? '0 : vcnt + VCW'(1);
    end else begin
      hcnt <= hcnt + HCW'(1);
    end
  end

  // Decode raw timing and framebuffer address for the current scan position.
  always_comb begin
    h32     = 32'(hcnt);
    v32     = 32'(vcnt);
    h_act   = (h32 >= H_DS) && (h32 < H_DE);
    v_act   = (v32 >= V_DS) && (v32 < V_DE);
    de_raw  = h_act && v_act;
    hs_raw  = (h32 < HR);
    vs_raw  = (v32 < VR);
    fs_raw  = (h32 == H_DS) && (v32 == V_DS);
    sx      = h32 - H_DS;
    sy      = v32 - V_DS;
    fx      = sx >> SCALE_LOG2;
    fy      = sy >> SCALE_LOG2;
    in_fb_c = de_raw && (fx < FB_W) && (fy < FB_H);
    addr_c  = in_fb_c ? FB_AW'(fy * FB_W + fx) : '0;
  end

  // Write port decode; in vblank-only mode writes wait for the vertical blank.
  always_comb begin
    wr_ready_o  = WR_VBLANK_ONLY ? !v_act : 1'b1;
    wr_in_range = (32'(wr_x_i) < FB_W) && (32'(wr_y_i) < FB_H);
    wr_accept   = wr_valid_i && wr_ready_o;
    fb_we       = wr_accept && wr_in_range;
    fb_waddr    = wr_in_range ? FB_AW'(32'(wr_y_i) * FB_W + 32'(wr_x_i)) : '0;
  end

  // Out-of-range accepted writes are discarded and flagged one cycle later.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) wr_drop_o <= 1'b0;
    else      wr_drop_o <= wr_accept && !wr_in_range;
  end

  // Stage 1: register address, in-fb flag and raw timing.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      s1_addr <= '0;
      s1_infb <= 1'b0;
      s1_de   <= 1'b0;
      s1_hs   <= 1'b0;
      s1_vs   <= 1'b0;
      s1_fs   <= 1'b0;
    end else begin
      s1_addr <= addr_c;
      s1_infb <= in_fb_c;
      s1_de   <= de_raw;
      s1_hs   <= hs_raw;
      s1_vs   <= vs_raw;
      s1_fs   <= fs_raw;
    end
  end

  // Framebuffer: one write, one synchronous read; read-during-write returns old data.
  always_ff @(posedge clk) begin
    if (fb_we) fb_mem[fb_waddr] <= wr_idx_i;
    fb_rdata <= fb_mem[s1_addr];
  end

  // Stage 2: carry timing alongside the framebuffer read.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      s2_infb <= 1'b0;
      s2_de   <= 1'b0;
      s2_hs   <= 1'b0;
      s2_vs   <= 1'b0;
      s2_fs   <= 1'b0;
    end else begin
      s2_infb <= s1_infb;
      s2_de   <= s1_de;
      s2_hs   <= s1_hs;
      s2_vs   <= s1_vs;
      s2_fs   <= s1_fs;
    end
  end

  // Pixels outside the framebuffer show palette entry 0 as a border.
  always_comb begin
    lkp_idx = '0;
    if (s2_infb) lkp_idx = fb_rdata;
  end

  // Palette registers; a write is seen by lookups from the following cycle.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int unsigned i = 0; i < PAL_N; i++) pal[i] <= '0;
    end else if (pal_we_i) begin
      pal[pal_addr_i] <= pal_data_i;
    end
  end

  // Stage 3: palette lookup and polarity-adjusted output registers.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      hsync_o       <= !HS_POL;
      vsync_o       <= !VS_POL;
      de_o          <= 1'b0;
      rgb_o         <= '0;
      frame_start_o <= 1'b0;
    end else begin
      hsync_o       <= s2_hs ? HS_POL : !HS_POL;
      vsync_o       <= s2_vs ? VS_POL : !VS_POL;
      de_o          <= s2_de;
      rgb_o         <= s2_de ? pal[lkp_idx] : '0;
      frame_start_o <= s2_fs;
    end
  end

endmodule
